// File: rtl/rst_gen_pkg.sv
// Shared types for the reset generator: FSM state encoding,
// reset-cause codes and the counter-width helper.
package rst_gen_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ASSERT = 2'd1;
    localparam state_t ST_HOLD   = 2'd2;

    localparam logic [1:0] CAUSE_POR  = 2'b00;
    localparam logic [1:0] CAUSE_BTN  = 2'b01;
    localparam logic [1:0] CAUSE_SW   = 2'b10;
    localparam logic [1:0] CAUSE_WDOG = 2'b11;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rst_gen_debounce.sv
// Pushbutton conditioner: two-flop synchronizer followed by a
// DEB_CYC stable-level filter; btn_evt pulses on a debounced press.
module rst_gen_debounce
    import rst_gen_pkg::*;
#(
    parameter int DEB_CYC = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic btn_lvl,
    output logic btn_evt
);

    localparam int DW = cnt_w(DEB_CYC);
    localparam logic [DW-1:0] D_LAST = DW'(DEB_CYC - 1);

    logic [1:0]    sync;
    logic [DW-1:0] cnt;
    logic          diff;
    logic          flip;

    assign diff = (sync[1] != btn_lvl);
    assign flip = diff && (cnt == D_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync    <= 2'b11;
            btn_lvl <= 1'b1;
            cnt     <= '0;
            btn_evt <= 1'b0;
        end else begin
            sync    <= {sync[0], btn_n};
            btn_evt <= flip && !sync[1];
            // any cycle matching the accepted level restarts the count
            if (flip) begin
                btn_lvl <= sync[1];
                cnt     <= '0;
            end else if (diff) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/rst_gen.sv
// System reset generator: power-on, button, software and watchdog
// reset sources. Define RST_GEN_WDOG_EN to build the watchdog.
module rst_gen
    import rst_gen_pkg::*;
#(
    parameter int PULSE_CYC = 16,
    parameter int DEB_CYC   = 50000,
    parameter int WDOG_CYC  = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_n,
    input  logic       sw_rst_req,
    input  logic       wdog_en,
    input  logic       wdog_kick,
    output logic       RST_n_out,
    output logic [1:0] rst_cause
);

    localparam int PW = cnt_w(PULSE_CYC);
    localparam logic [PW-1:0] P_LAST = PW'(PULSE_CYC - 1);

    state_t        state;
    state_t        state_nxt;
    logic [1:0]    cause_nxt;
    logic [PW-1:0] pcnt;
    logic          btn_lvl;
    logic          btn_evt;
    logic          wdog_evt;

    rst_gen_debounce #(
        .DEB_CYC(DEB_CYC)
    ) u_deb (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_n  (btn_n),
        .btn_lvl(btn_lvl),
        .btn_evt(btn_evt)
    );

`ifdef RST_GEN_WDOG_EN
    localparam int WW = cnt_w(WDOG_CYC);
    localparam logic [WW-1:0] W_LAST = WW'(WDOG_CYC - 1);

    logic [WW-1:0] wcnt;

    // a kick in the timeout cycle only clears the counter, not the event
    assign wdog_evt = (state == ST_IDLE) && wdog_en && (wcnt == W_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n || state != ST_IDLE || !wdog_en || wdog_kick) begin
            wcnt <= '0;
        end else if (wcnt != W_LAST) begin
            wcnt <= wcnt + 1'b1;
        end
    end
`else
    localparam int unused_wdog_cyc = WDOG_CYC;
    logic unused_wdog;
    assign unused_wdog = wdog_en ^ wdog_kick;
    assign wdog_evt    = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        cause_nxt = rst_cause;
        unique case (state)
            ST_IDLE: begin
                if (wdog_evt) begin
                    state_nxt = ST_ASSERT;
                    cause_nxt = CAUSE_WDOG;
                end else if (btn_evt) begin
                    state_nxt = ST_ASSERT;
                    cause_nxt = CAUSE_BTN;
                end else if (sw_rst_req) begin
                    state_nxt = ST_ASSERT;
                    cause_nxt = CAUSE_SW;
                end
            end
            // a released button skips HOLD so the pulse is exactly PULSE_CYC
            ST_ASSERT: begin
                if (pcnt == P_LAST) begin
                    state_nxt = btn_lvl ? ST_IDLE : ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (btn_lvl) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_ASSERT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_ASSERT;
            pcnt      <= '0;
            rst_cause <= CAUSE_POR;
            RST_n_out <= 1'b0;
        end else begin
            state     <= state_nxt;
            rst_cause <= cause_nxt;
            RST_n_out <= (state_nxt == ST_IDLE);
            if (state == ST_ASSERT && pcnt != P_LAST) begin
                pcnt <= pcnt + 1'b1;
            end else begin
                pcnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rst_gen.sv
// Directed testbench for rst_gen with PULSE_CYC=4, DEB_CYC=3,
// WDOG_CYC=20; watchdog scenarios follow RST_GEN_WDOG_EN.
module tb_rst_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_n = 1'b1;
    logic       sw_rst_req = 1'b0;
    logic       wdog_en = 1'b0;
    logic       wdog_kick = 1'b0;
    logic       RST_n_out;
    logic [1:0] rst_cause;

    int pass_cnt = 0;
    int total = 0;

    always #5 clk = ~clk;

    rst_gen #(
        .PULSE_CYC(4),
        .DEB_CYC  (3),
        .WDOG_CYC (20)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_n     (btn_n),
        .sw_rst_req(sw_rst_req),
        .wdog_en   (wdog_en),
        .wdog_kick (wdog_kick),
        .RST_n_out (RST_n_out),
        .rst_cause (rst_cause)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step(5);
        total++;
        if (RST_n_out !== 1'b0) $display("FAIL por_in_reset got %b want 0", RST_n_out);
        else pass_cnt++;
        total++;
        if (rst_cause !== 2'b00) $display("FAIL por_cause_rst got %b want 00", rst_cause);
        else pass_cnt++;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            total++;
            if (RST_n_out !== 1'b0) $display("FAIL por_hold%0d got %b want 0", i, RST_n_out);
            else pass_cnt++;
        end
        step(1);
        total++;
        if (RST_n_out !== 1'b1) $display("FAIL por_end got %b want 1", RST_n_out);
        else pass_cnt++;
        total++;
        if (rst_cause !== 2'b00) $display("FAIL por_cause got %b want 00", rst_cause);
        else pass_cnt++;
    endtask

    task automatic test_sw;
        sw_rst_req = 1'b1;
        step(1);
        sw_rst_req = 1'b0;
        total++;
        if (rst_cause !== 2'b10) $display("FAIL sw_cause got %b want 10", rst_cause);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (RST_n_out !== 1'b0) $display("FAIL sw_low%0d got %b want 0", i, RST_n_out);
            else pass_cnt++;
            step(1);
        end
        total++;
        if (RST_n_out !== 1'b1) $display("FAIL sw_end got %b want 1", RST_n_out);
        else pass_cnt++;
    endtask

    task automatic test_btn_bounce;
        btn_n = 1'b0;
        step(2);
        btn_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1);
            total++;
            if (RST_n_out !== 1'b1) $display("FAIL bounce_out%0d got %b want 1", i, RST_n_out);
            else pass_cnt++;
        end
        total++;
        if (rst_cause !== 2'b10) $display("FAIL bounce_cause got %b want 10", rst_cause);
        else pass_cnt++;
    endtask

    task automatic test_btn_short;
        btn_n = 1'b0;
        step(3);
        btn_n = 1'b1;
        step(2);
        total++;
        if (RST_n_out !== 1'b1) $display("FAIL short_pre got %b want 1", RST_n_out);
        else pass_cnt++;
        step(1);
        total++;
        if (RST_n_out !== 1'b0) $display("FAIL short_start got %b want 0", RST_n_out);
        else pass_cnt++;
        total++;
        if (rst_cause !== 2'b01) $display("FAIL short_cause got %b want 01", rst_cause);
        else pass_cnt++;
        step(3);
        total++;
        if (RST_n_out !== 1'b0) $display("FAIL short_last got %b want 0", RST_n_out);
        else pass_cnt++;
        step(1);
        total++;
        if (RST_n_out !== 1'b1) $display("FAIL short_end got %b want 1", RST_n_out);
        else pass_cnt++;
    endtask

    task automatic test_sw_during_assert;
        sw_rst_req = 1'b1;
        step(1);
        sw_rst_req = 1'b0;
        step(1);
        sw_rst_req = 1'b1;
        step(1);
        sw_rst_req = 1'b0;
        total++;
        if (RST_n_out !== 1'b0) $display("FAIL swa_mid got %b want 0", RST_n_out);
        else pass_cnt++;
        step(1);
        total++;
        if (RST_n_out !== 1'b0) $display("FAIL swa_last got %b want 0", RST_n_out);
        else pass_cnt++;
        step(1);
        total++;
        if (RST_n_out !== 1'b1) $display("FAIL swa_end got %b want 1", RST_n_out);
        else pass_cnt++;
        step(2);
        total++;
        if (RST_n_out !== 1'b1) $display("FAIL swa_idle got %b want 1", RST_n_out);
        else pass_cnt++;
        total++;
        if (rst_cause !== 2'b10) $display("FAIL swa_cause got %b want 10", rst_cause);
        else pass_cnt++;
    endtask

    task automatic test_btn_long;
        btn_n = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step(1);
            total++;
            if (RST_n_out !== 1'b1) $display("FAIL long_pre%0d got %b want 1", i, RST_n_out);
            else pass_cnt++;
        end
        step(1);
        total++;
        if (RST_n_out !== 1'b0) $display("FAIL long_start got %b want 0", RST_n_out);
        else pass_cnt++;
        total++;
        if (rst_cause !== 2'b01) $display("FAIL long_cause got %b want 01", rst_cause);
        else pass_cnt++;
        step(4);
        btn_n = 1'b1;
        step(1);
        sw_rst_req = 1'b1;
        step(1);
        sw_rst_req = 1'b0;
        total++;
        if (RST_n_out !== 1'b0) $display("FAIL long_hold got %b want 0", RST_n_out);
        else pass_cnt++;
        total++;
        if (rst_cause !== 2'b01) $display("FAIL long_hold_cause got %b want 01", rst_cause);
        else pass_cnt++;
        step(3);
        total++;
        if (RST_n_out !== 1'b0) $display("FAIL long_hold_last got %b want 0", RST_n_out);
        else pass_cnt++;
        step(1);
        total++;
        if (RST_n_out !== 1'b1) $display("FAIL long_release got %b want 1", RST_n_out);
        else pass_cnt++;
        step(4);
        total++;
        if (RST_n_out !== 1'b1) $display("FAIL long_after got %b want 1", RST_n_out);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        sw_rst_req = 1'b1;
        step(1);
        sw_rst_req = 1'b0;
        step(1);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        total++;
        if (rst_cause !== 2'b00) $display("FAIL mid_cause got %b want 00", rst_cause);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            step(1);
            total++;
            if (RST_n_out !== 1'b0) $display("FAIL mid_hold%0d got %b want 0", i, RST_n_out);
            else pass_cnt++;
        end
        step(1);
        total++;
        if (RST_n_out !== 1'b1) $display("FAIL mid_end got %b want 1", RST_n_out);
        else pass_cnt++;
    endtask

`ifdef RST_GEN_WDOG_EN
    task automatic test_wdog;
        wdog_en = 1'b1;
        for (int i = 0; i < 19; i++) begin
            step(1);
            total++;
            if (RST_n_out !== 1'b1) $display("FAIL wdog_pre%0d got %b want 1", i, RST_n_out);
            else pass_cnt++;
        end
        sw_rst_req = 1'b1;
        wdog_kick = 1'b1;
        step(1);
        sw_rst_req = 1'b0;
        wdog_kick = 1'b0;
        wdog_en = 1'b0;
        total++;
        if (RST_n_out !== 1'b0) $display("FAIL wdog_fire got %b want 0", RST_n_out);
        else pass_cnt++;
        total++;
        if (rst_cause !== 2'b11) $display("FAIL wdog_cause got %b want 11", rst_cause);
        else pass_cnt++;
        step(4);
        total++;
        if (RST_n_out !== 1'b1) $display("FAIL wdog_end got %b want 1", RST_n_out);
        else pass_cnt++;
        wdog_en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            wdog_kick = (i % 10 == 9);
            step(1);
            total++;
            if (RST_n_out !== 1'b1) $display("FAIL wdog_kick%0d got %b want 1", i, RST_n_out);
            else pass_cnt++;
        end
        wdog_kick = 1'b0;
        wdog_en = 1'b0;
        step(1);
        wdog_en = 1'b1;
        step(15);
        wdog_en = 1'b0;
        step(1);
        wdog_en = 1'b1;
        step(15);
        wdog_en = 1'b0;
        total++;
        if (RST_n_out !== 1'b1) $display("FAIL wdog_en_clear got %b want 1", RST_n_out);
        else pass_cnt++;
        total++;
        if (rst_cause !== 2'b11) $display("FAIL wdog_cause_hold got %b want 11", rst_cause);
        else pass_cnt++;
    endtask
`else
    task automatic test_wdog;
        wdog_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            wdog_kick = (i == 25);
            step(1);
            total++;
            if (RST_n_out !== 1'b1) $display("FAIL nowdog_out%0d got %b want 1", i, RST_n_out);
            else pass_cnt++;
        end
        wdog_kick = 1'b0;
        wdog_en = 1'b0;
        total++;
        if (rst_cause !== 2'b00) $display("FAIL nowdog_cause got %b want 00", rst_cause);
        else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_sw();
        test_btn_bounce();
        test_btn_short();
        test_sw_during_assert();
        test_btn_long();
        test_reset_mid();
        test_wdog();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/rst_gen.md
RST_GEN -- requirements
Module: rst_gen

Interface
REQ-001 SHALL have parameter PULSE_CYC, default 16: minimum number of clk cycles RST_n_out is held low per reset event.
REQ-002 SHALL have parameter DEB_CYC, default 50000: number of consecutive stable clk cycles needed to accept a button level.
REQ-003 SHALL have parameter WDOG_CYC, default 1000000: watchdog timeout in clk cycles.
REQ-004 SHALL have port clk, input, 1: single system clock; all logic SHALL be on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port btn_n, input, 1: raw asynchronous pushbutton, active-low.
REQ-007 SHALL have port sw_rst_req, input, 1: single-cycle software reset request, synchronous to clk.
REQ-008 SHALL have port wdog_en, input, 1: watchdog enable, synchronous.
REQ-009 SHALL have port wdog_kick, input, 1: single-cycle watchdog restart, synchronous.
REQ-010 SHALL have port RST_n_out, output, 1: generated system reset request, active-low, registered.
REQ-011 SHALL have port rst_cause, output, 2: cause of last reset; 00 power-on, 01 button, 10 software, 11 watchdog.

Function
REQ-012 SHALL pass btn_n through a two-flop synchronizer before any other use.
REQ-013 SHALL update the debounced button level only after the synchronized value differs from it for DEB_CYC consecutive cycles; any bounce SHALL restart the debounce count.
REQ-014 SHALL treat a 1->0 transition of the debounced level as a button event.
REQ-015 SHALL implement FSM states IDLE, ASSERT, HOLD.
REQ-016 IDLE: RST_n_out=1; on any event -> ASSERT, pulse counter cleared, rst_cause updated the same cycle.
REQ-017 ASSERT: RST_n_out=0; pulse counter increments; -> HOLD after exactly PULSE_CYC cycles in ASSERT.
REQ-018 HOLD: RST_n_out=0; -> IDLE in the first cycle the debounced button is released (1); otherwise stays.
REQ-019 Simultaneous events SHALL resolve with priority watchdog > button > software for rst_cause.
REQ-020 Events arriving in ASSERT or HOLD SHALL be ignored; they SHALL NOT restart the pulse or change rst_cause.
REQ-021 rst_cause SHALL hold its value until the next accepted event.
REQ-022 Watchdog counter SHALL count in IDLE while wdog_en=1, clear on wdog_kick or wdog_en=0, and raise an event when it reaches WDOG_CYC-1.
REQ-023 Watchdog counter SHALL be cleared in ASSERT and HOLD; a kick on the event cycle SHALL NOT cancel the event.
REQ-024 Counter widths SHALL be $clog2 of the respective parameter, minimum 1; counters SHALL never wrap.

Reset
REQ-025 rst_n=0 SHALL force state ASSERT, clear all counters, set rst_cause=00, RST_n_out=0, and load the synchronizer and debounced level with 1.
REQ-026 After rst_n returns to 1, RST_n_out SHALL stay low for PULSE_CYC further cycles (power-on pulse).
REQ-027 rst_n asserted mid-pulse SHALL restart the full power-on sequence.

Configuration
REQ-028 Macro RST_GEN_WDOG_EN defined: watchdog per REQ-022/023 is built in.
REQ-029 Macro undefined: no watchdog counter; wdog_en and wdog_kick remain as ports but are ignored; rst_cause never 11.

Structure
REQ-030 Shared package rst_gen_pkg SHALL hold the FSM state typedef and the rst_cause encoding constants.
REQ-031 Debounce logic SHALL be sub-module rst_gen_debounce (synchronizer plus DEB_CYC filter), instantiated once.

Verification (PULSE_CYC=4, DEB_CYC=3, WDOG_CYC=20)
REQ-032 Release rst_n after 5 cycles -> RST_n_out low for exactly 4 more cycles, then 1; rst_cause=00.
REQ-033 btn_n low for 2 cycles then high -> no event; btn_n low 10 cycles -> RST_n_out low from 6 cycles after the falling edge (2 sync + 3 debounce + 1 event) until release; rst_cause=01.
REQ-034 sw_rst_req pulse in IDLE -> RST_n_out low for 4 cycles starting next cycle; rst_cause=10.
REQ-035 Macro defined, wdog_en=1, no kick -> event 20 cycles after enable, rst_cause=11; kick every 10 cycles -> no event.
REQ-036 sw_rst_req and watchdog timeout in the same cycle -> rst_cause=11; sw_rst_req during ASSERT -> pulse length unchanged at 4.
